word_score_accumulator: RTL
===========================

// Module: word_score_accumulator
// PURPOSE
//   Sequential, parametrised successor to the combinational word-match scorer.
//   Scores one match-flag sample per accepted handshake and accumulates a
//   saturating total over a game of ROUNDS rounds.
//   Sits between the word-compare datapath and the display/score register file.
// PARAMETERS
//   SCORE_W     16   width of the per-round score and of the running total
//   ROUNDS      8    rounds per game (>=1)
//   SCORE_BONUS 10   score when second_half && flag
//   SCORE_FULL  8    score when full_match (and not bonus)
//   SCORE_HALF  5    score when first_half (and neither of the above)
//   SCORE_MISS  2    score otherwise
//   CNT_W       $clog2(ROUNDS+1)  round counter width
// PORTS
//   clk          in   1        single clock, all logic on rising edge
//   reset        in   1        synchronous, active-high reset
//   start        in   1        begin a new game (honoured in IDLE and DONE only)
//   in_valid     in   1        match flags below are valid this cycle
//   in_ready     out  1        block accepts a sample this cycle
//   full_match   in   1        whole word matched
//   first_half   in   1        first half matched
//   second_half  in   1        second half matched
//   flag         in   1        bonus qualifier for second_half
//   score_valid  out  1        one-cycle pulse: score holds a new round score
//   score        out  SCORE_W  last round score (holds until next accept)
//   total        out  SCORE_W  running game total, saturating
//   round_idx    out  CNT_W    rounds accepted so far in this game
//   saturated    out  1        sticky: total clipped at least once this game
//   busy         out  1        FSM in RUN
//   done         out  1        FSM in DONE (level, held until start/reset)
// BEHAVIOUR
//   - Reset: FSM=IDLE; in_ready, score_valid, saturated, busy, done = 0;
//     score, total, round_idx = 0. Reset wins over every other input.
//   - FSM states IDLE, RUN, DONE.
//     IDLE: in_ready=0. start=1 -> RUN; total, round_idx, saturated, score
//       are cleared on that same edge.
//     RUN: in_ready=1, busy=1; start ignored. Accept = in_valid && in_ready.
//       On accept, with round_idx==ROUNDS-1 -> DONE on that edge.
//     DONE: in_ready=0, done=1; start=1 -> RUN with same clearing as IDLE.
//   - Round score, evaluated on the accept cycle, strict priority:
//     second_half&&flag -> SCORE_BONUS; else full_match -> SCORE_FULL;
//     else first_half -> SCORE_HALF; else SCORE_MISS. Constants truncate to
//     SCORE_W.
//   - Latency: one cycle. Registered on the accept edge: score, total,
//     round_idx+1, and score_valid=1 for exactly one cycle. score_valid=0 in
//     every cycle not following an accept.
//   - total: unsigned add in SCORE_W+1 bits. On carry out, total=2^SCORE_W-1
//     and saturated=1 (sticky until next start or reset). Once at max, total
//     stays at max.
//   - Back-to-back accepts every cycle are supported; no bubbles.
//   - in_valid outside RUN is dropped, with no state change.
//   - Mid-game reset: everything returns to reset values. No partial total
//     survives.
//   - The final-round score_valid pulse coincides with the first done cycle.
// TESTING
//   1 reset, start, 4 samples (sh&f, full, first, none) -> score 10,8,5,2;
//     total 10,18,23,25; round_idx 1..4.
//   2 priority: all four flags=1 -> 10; full+first -> 8; second_half without
//     flag -> MISS or HALF/FULL as per other flags.
//   3 ROUNDS=8, 8 back-to-back accepts -> done=1 the cycle after the 8th;
//     in_ready=0; a 9th in_valid is ignored and total is unchanged.
//   4 SCORE_W=4, 2 bonus rounds -> total 10 then 15, saturated=1; further
//     rounds hold 15.
//   5 reset asserted in round 3 of RUN -> next cycle IDLE, all outputs 0;
//     start re-runs a clean game.
//   6 start pulsed during RUN -> ignored; start in DONE -> RUN with total=0
//     and saturated=0.

Source files
------------

// File: rtl/word_score_accumulator.sv
// ============================================================================
// Module      : word_score_accumulator
// Description : Scores one match-flag sample per accepted handshake and keeps a
//               saturating running total over a game of ROUNDS rounds.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module word_score_accumulator #(
  parameter int SCORE_W     = 16,
  parameter int ROUNDS      = 8,
  parameter int SCORE_BONUS = 10,
  parameter int SCORE_FULL  = 8,
  parameter int SCORE_HALF  = 5,
  parameter int SCORE_MISS  = 2,
  parameter int CNT_W       = $clog2(ROUNDS + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               full_match,
  input  logic               first_half,
  input  logic               second_half,
  input  logic               flag,
  output logic               score_valid,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] total,
  output logic [CNT_W-1:0]   round_idx,
  output logic               saturated,
  output logic               busy,
  output logic               done
);

  localparam logic [SCORE_W-1:0] c_BONUS     = SCORE_W'(SCORE_BONUS);
  localparam logic [SCORE_W-1:0] c_FULL      = SCORE_W'(SCORE_FULL);
  localparam logic [SCORE_W-1:0] c_HALF      = SCORE_W'(SCORE_HALF);
  localparam logic [SCORE_W-1:0] c_MISS      = SCORE_W'(SCORE_MISS);
  localparam logic [SCORE_W-1:0] c_MAX       = {SCORE_W{1'b1}};
  localparam logic [CNT_W-1:0]   c_LAST_ROUND = CNT_W'(ROUNDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic               w_accept;
  logic               w_clear;
  logic [SCORE_W-1:0] w_round_score;
  logic [SCORE_W:0]   w_sum;

  logic               r_score_valid;
  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W-1:0] r_total;
  logic [CNT_W-1:0]   r_round_idx;
  logic               r_saturated;

  assign in_ready = (r_state == S_RUN);
  assign busy     = (r_state == S_RUN);
  assign done     = (r_state == S_DONE);
  assign w_accept = in_valid && in_ready;
  assign w_clear  = start && (r_state != S_RUN);

  always_comb begin
    w_round_score = c_MISS;
    if (second_half && flag) begin
      w_round_score = c_BONUS;
    end else if (full_match) begin
      w_round_score = c_FULL;
    end else if (first_half) begin
      w_round_score = c_HALF;
    end
  end

  // Carry out of the widened add marks a clipped total.
  assign w_sum = {1'b0, r_total} + {1'b0, w_round_score};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_RUN;
        end
      end
      S_RUN: begin
        if (w_accept && (r_round_idx == c_LAST_ROUND)) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          w_next_state = S_RUN;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_score_valid <= 1'b0;
      r_score       <= '0;
      r_total       <= '0;
      r_round_idx   <= '0;
      r_saturated   <= 1'b0;
    end else if (w_clear) begin
      r_score_valid <= 1'b0;
      r_score       <= '0;
      r_total       <= '0;
      r_round_idx   <= '0;
      r_saturated   <= 1'b0;
    end else if (w_accept) begin
      r_score_valid <= 1'b1;
      r_score       <= w_round_score;
      r_round_idx   <= r_round_idx + 1'b1;
      if (w_sum[SCORE_W]) begin
        r_total     <= c_MAX;
        r_saturated <= 1'b1;
      end else begin
        r_total     <= w_sum[SCORE_W-1:0];
      end
    end else begin
      r_score_valid <= 1'b0;
    end
  end

  assign score_valid = r_score_valid;
  assign score       = r_score;
  assign total       = r_total;
  assign round_idx   = r_round_idx;
  assign saturated   = r_saturated;

endmodule

`default_nettype wire
